// File: rtl/clock_set_pkg.sv
// Shared constants and helpers for the user time-set controller and the clock counter chain.
package clock_set_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned DAY_W  = 5;
    localparam int unsigned MONT_W = 4;
    localparam int unsigned YEAR_W = 13;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MONT_MAX = 12;

    localparam int unsigned ST_W = 3;
    localparam int unsigned FS_W = 3;

    // Edit states share their encoding with field_sel so that ST_SEC + 1 lands on ST_COMMIT.
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_YEAR   = 3'd1;
    localparam logic [ST_W-1:0] ST_MONT   = 3'd2;
    localparam logic [ST_W-1:0] ST_DAY    = 3'd3;
    localparam logic [ST_W-1:0] ST_HOUR   = 3'd4;
    localparam logic [ST_W-1:0] ST_MIN    = 3'd5;
    localparam logic [ST_W-1:0] ST_SEC    = 3'd6;
    localparam logic [ST_W-1:0] ST_COMMIT = 3'd7;

    localparam logic [FS_W-1:0] FS_NONE = 3'd0;
    localparam logic [FS_W-1:0] FS_YEAR = 3'd1;
    localparam logic [FS_W-1:0] FS_MONT = 3'd2;
    localparam logic [FS_W-1:0] FS_DAY  = 3'd3;
    localparam logic [FS_W-1:0] FS_HOUR = 3'd4;
    localparam logic [FS_W-1:0] FS_MIN  = 3'd5;
    localparam logic [FS_W-1:0] FS_SEC  = 3'd6;

    // One modular step inside [lo, hi]; out-of-range values snap to the wrap target.
    function automatic logic [YEAR_W-1:0] step_wrap(input logic [YEAR_W-1:0] v,
                                                   input logic [YEAR_W-1:0] lo,
                                                   input logic [YEAR_W-1:0] hi,
                                                   input logic up);
        if (up) begin
            return (v >= hi) ? lo : v + YEAR_W'(1);
        end
        return (v <= lo) ? hi : v - YEAR_W'(1);
    endfunction

endpackage

// File: rtl/days_in_month.sv
// Month length with Gregorian leap rule; shared with the clock counter's day rollover.
module days_in_month
    import clock_set_pkg::*;
(
    input  logic [MONT_W-1:0] mont,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  dim
);

    logic leap;

    always_comb begin
        leap = (year[1:0] == 2'd0) &&
               (((year % YEAR_W'(100)) != '0) || ((year % YEAR_W'(400)) == '0));
        case (mont)
            4'd2:                      dim = leap ? DAY_W'(29) : DAY_W'(28);
            4'd4, 4'd6, 4'd9, 4'd11:   dim = DAY_W'(30);
            default:                   dim = DAY_W'(31);
        endcase
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// User time-set controller: captures live time into shadow registers, edits field by field,
// and pulses load towards the clock counter on commit.
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int unsigned YEAR_MIN = 1900,
    parameter int unsigned YEAR_MAX = 2099,
    parameter int unsigned TIMEOUT  = 30
) (
    input  logic              clk_1Hz,
    input  logic              rst_n,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              btn_ok,
    input  logic              btn_cancel,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [DAY_W-1:0]  cur_day,
    input  logic [MONT_W-1:0] cur_mont,
    input  logic [YEAR_W-1:0] cur_year,
    output logic              set_mode,
    output logic [FS_W-1:0]   field_sel,
    output logic              load,
    output logic [SEC_W-1:0]  ld_sec,
    output logic [MIN_W-1:0]  ld_min,
    output logic [HOUR_W-1:0] ld_hour,
    output logic [DAY_W-1:0]  ld_day,
    output logic [MONT_W-1:0] ld_mont,
    output logic [YEAR_W-1:0] ld_year
);

    localparam int unsigned       TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LIM = TO_W'(TIMEOUT);
    localparam logic [YEAR_W-1:0] YMIN   = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] YMAX   = YEAR_W'(YEAR_MAX);

    logic [ST_W-1:0]   state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              set_mode_q, set_mode_d;
    logic [FS_W-1:0]   field_sel_q, field_sel_d;
    logic              load_q, load_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic [DAY_W-1:0]  day_q, day_d;
    logic [MONT_W-1:0] mont_q, mont_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [DAY_W-1:0]  dim_cur, dim_nxt;

    logic any_btn, edit_en, capture;

    assign any_btn = btn_mode | btn_inc | btn_dec | btn_ok | btn_cancel;
    assign edit_en = (btn_inc ^ btn_dec) & ~btn_cancel & ~btn_ok & ~btn_mode;
    assign capture = (state_q == ST_IDLE) & btn_mode;

    // dim_cur bounds day editing; dim_nxt clamps the day against the month/year being written.
    days_in_month u_dim_cur (.mont(mont_q), .year(year_q), .dim(dim_cur));
    days_in_month u_dim_nxt (.mont(mont_d), .year(year_d), .dim(dim_nxt));

    // Next state, timeout counter and all shadow fields except day.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        mont_d   = mont_q;
        year_d   = year_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_mode) begin
                    state_d = ST_YEAR;
                    sec_d   = cur_sec;
                    min_d   = cur_min;
                    hour_d  = cur_hour;
                    mont_d  = cur_mont;
                    if (cur_year < YMIN) begin
                        year_d = YMIN;
                    end else if (cur_year > YMAX) begin
                        year_d = YMAX;
                    end else begin
                        year_d = cur_year;
                    end
                end
            end
            ST_YEAR, ST_MONT, ST_DAY, ST_HOUR, ST_MIN, ST_SEC: begin
                to_cnt_d = any_btn ? '0 : to_cnt_q + TO_W'(1);
                if (btn_cancel) begin
                    state_d = ST_IDLE;
                end else if (btn_ok) begin
                    state_d = ST_COMMIT;
                end else if (btn_mode) begin
                    state_d = state_q + ST_W'(1);
                end else if (edit_en) begin
                    case (state_q)
                        ST_YEAR: year_d = step_wrap(year_q, YMIN, YMAX, btn_inc);
                        ST_MONT: mont_d = MONT_W'(step_wrap(YEAR_W'(mont_q), YEAR_W'(1),
                                                            YEAR_W'(MONT_MAX), btn_inc));
                        ST_HOUR: hour_d = HOUR_W'(step_wrap(YEAR_W'(hour_q), '0,
                                                            YEAR_W'(HOUR_MAX), btn_inc));
                        ST_MIN:  min_d  = MIN_W'(step_wrap(YEAR_W'(min_q), '0,
                                                           YEAR_W'(MIN_MAX), btn_inc));
                        ST_SEC:  sec_d  = SEC_W'(step_wrap(YEAR_W'(sec_q), '0,
                                                           YEAR_W'(SEC_MAX), btn_inc));
                        default: ;
                    endcase
                end else if (!any_btn && to_cnt_d == TO_LIM) begin
                    state_d  = ST_IDLE;
                    to_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Day edit plus clamp to the length of the month being written this cycle.
    always_comb begin
        day_d = day_q;
        if (capture) begin
            day_d = cur_day;
        end else if (edit_en && state_q == ST_DAY) begin
            day_d = DAY_W'(step_wrap(YEAR_W'(day_q), YEAR_W'(1), YEAR_W'(dim_cur), btn_inc));
        end
        if (day_d > dim_nxt) begin
            day_d = dim_nxt;
        end
    end

    always_comb begin
        set_mode_d = (state_d != ST_IDLE);
        load_d     = (state_d == ST_COMMIT);
        case (state_d)
            ST_YEAR: field_sel_d = FS_YEAR;
            ST_MONT: field_sel_d = FS_MONT;
            ST_DAY:  field_sel_d = FS_DAY;
            ST_HOUR: field_sel_d = FS_HOUR;
            ST_MIN:  field_sel_d = FS_MIN;
            ST_SEC:  field_sel_d = FS_SEC;
            default: field_sel_d = FS_NONE;
        endcase
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            to_cnt_q    <= '0;
            set_mode_q  <= 1'b0;
            field_sel_q <= FS_NONE;
            load_q      <= 1'b0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            day_q       <= DAY_W'(1);
            mont_q      <= MONT_W'(1);
            year_q      <= YMIN;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            set_mode_q  <= set_mode_d;
            field_sel_q <= field_sel_d;
            load_q      <= load_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            mont_q      <= mont_d;
            year_q      <= year_d;
        end
    end

    assign set_mode  = set_mode_q;
    assign field_sel = field_sel_q;
    assign load      = load_q;
    assign ld_sec    = sec_q;
    assign ld_min    = min_q;
    assign ld_hour   = hour_q;
    assign ld_day    = day_q;
    assign ld_mont   = mont_q;
    assign ld_year   = year_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a vector table plus timeout and reset sequences.
module tb_clock_set_ctrl;

    typedef struct packed {
        logic [12:0] y;
        logic [3:0]  mo;
        logic [4:0]  d;
        logic [4:0]  h;
        logic [5:0]  mi;
        logic [5:0]  s;
    } date_t;

    typedef struct {
        string       name;
        logic [4:0]  btn;
        date_t       cur;
        logic        sm;
        logic [2:0]  fs;
        logic        ld;
        date_t       exp;
    } vec_t;

    localparam logic [4:0] B_NONE   = 5'b00000;
    localparam logic [4:0] B_DEC    = 5'b00001;
    localparam logic [4:0] B_INC    = 5'b00010;
    localparam logic [4:0] B_MODE   = 5'b00100;
    localparam logic [4:0] B_OK     = 5'b01000;
    localparam logic [4:0] B_CANCEL = 5'b10000;

    logic        clk_1Hz = 1'b0;
    logic        rst_n;
    logic [4:0]  btn_v;
    date_t       cur_v;
    logic        btn_mode, btn_inc, btn_dec, btn_ok, btn_cancel;
    logic        set_mode, load;
    logic [2:0]  field_sel;
    logic [5:0]  ld_sec, ld_min;
    logic [4:0]  ld_hour, ld_day;
    logic [3:0]  ld_mont;
    logic [12:0] ld_year;

    int n_vec = 0;
    int n_err = 0;
    vec_t  vecs[$];
    date_t bc;

    assign {btn_cancel, btn_ok, btn_mode, btn_inc, btn_dec} = btn_v;

    always #5 clk_1Hz = ~clk_1Hz;

    clock_set_ctrl dut (
        .clk_1Hz   (clk_1Hz),
        .rst_n     (rst_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .btn_ok    (btn_ok),
        .btn_cancel(btn_cancel),
        .cur_sec   (cur_v.s),
        .cur_min   (cur_v.mi),
        .cur_hour  (cur_v.h),
        .cur_day   (cur_v.d),
        .cur_mont  (cur_v.mo),
        .cur_year  (cur_v.y),
        .set_mode  (set_mode),
        .field_sel (field_sel),
        .load      (load),
        .ld_sec    (ld_sec),
        .ld_min    (ld_min),
        .ld_hour   (ld_hour),
        .ld_day    (ld_day),
        .ld_mont   (ld_mont),
        .ld_year   (ld_year)
    );

    function automatic date_t mkd(int y, int mo, int d, int h, int mi, int s);
        date_t r;
        r.y = 13'(y); r.mo = 4'(mo); r.d = 5'(d); r.h = 5'(h); r.mi = 6'(mi); r.s = 6'(s);
        return r;
    endfunction

    function automatic string fmt(date_t x);
        return $sformatf("%0d-%0d-%0d %0d:%0d:%0d", x.y, x.mo, x.d, x.h, x.mi, x.s);
    endfunction

    function automatic void add(string n, logic [4:0] b, logic sm, logic [2:0] fs, logic ld,
                                date_t e);
        vec_t v;
        v.name = n; v.btn = b; v.cur = bc; v.sm = sm; v.fs = fs; v.ld = ld; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic sm, logic [2:0] fs, logic ld, date_t e);
        date_t a;
        a = {ld_year, ld_mont, ld_day, ld_hour, ld_min, ld_sec};
        n_vec++;
        if ({set_mode, field_sel, load, a} !== {sm, fs, ld, e}) begin
            n_err++;
            $display("FAIL %s: got set_mode=%0d field_sel=%0d load=%0d ld=%s, want set_mode=%0d field_sel=%0d load=%0d ld=%s",
                     name, set_mode, field_sel, load, fmt(a), sm, fs, ld, fmt(e));
        end
    endtask

    task automatic step(input logic [4:0] b);
        btn_v = b;
        @(posedge clk_1Hz);
        #1;
        btn_v = B_NONE;
    endtask

    initial begin
        date_t r0, t;
        r0 = mkd(1900, 1, 1, 0, 0, 0);

        bc = mkd(2024, 2, 28, 23, 59, 58);
        add("idle_none",    B_NONE,        0, 0, 0, r0);
        add("idle_inc_ign", B_INC,         0, 0, 0, r0);
        add("capture",      B_MODE,        1, 1, 0, mkd(2024, 2, 28, 23, 59, 58));
        add("year_inc",     B_INC,         1, 1, 0, mkd(2025, 2, 28, 23, 59, 58));
        add("year_dec",     B_DEC,         1, 1, 0, mkd(2024, 2, 28, 23, 59, 58));
        add("to_mont",      B_MODE,        1, 2, 0, mkd(2024, 2, 28, 23, 59, 58));
        add("inc_dec_both", B_INC | B_DEC, 1, 2, 0, mkd(2024, 2, 28, 23, 59, 58));
        add("mode_inc",     B_MODE | B_INC,1, 3, 0, mkd(2024, 2, 28, 23, 59, 58));
        add("day_inc_leap", B_INC,         1, 3, 0, mkd(2024, 2, 29, 23, 59, 58));
        add("day_wrap_up",  B_INC,         1, 3, 0, mkd(2024, 2, 1, 23, 59, 58));
        add("day_wrap_dn",  B_DEC,         1, 3, 0, mkd(2024, 2, 29, 23, 59, 58));
        add("to_hour",      B_MODE,        1, 4, 0, mkd(2024, 2, 29, 23, 59, 58));
        add("hour_wrap_up", B_INC,         1, 4, 0, mkd(2024, 2, 29, 0, 59, 58));
        add("hour_wrap_dn", B_DEC,         1, 4, 0, mkd(2024, 2, 29, 23, 59, 58));
        add("to_min",       B_MODE,        1, 5, 0, mkd(2024, 2, 29, 23, 59, 58));
        add("min_dec",      B_DEC,         1, 5, 0, mkd(2024, 2, 29, 23, 58, 58));
        add("to_sec",       B_MODE,        1, 6, 0, mkd(2024, 2, 29, 23, 58, 58));
        add("sec_inc",      B_INC,         1, 6, 0, mkd(2024, 2, 29, 23, 58, 59));
        add("sec_wrap",     B_INC,         1, 6, 0, mkd(2024, 2, 29, 23, 58, 0));
        add("mode_commit",  B_MODE,        1, 0, 1, mkd(2024, 2, 29, 23, 58, 0));
        add("after_commit", B_NONE,        0, 0, 0, mkd(2024, 2, 29, 23, 58, 0));

        bc = mkd(2024, 2, 29, 10, 20, 30);
        add("cap_feb29",    B_MODE,        1, 1, 0, mkd(2024, 2, 29, 10, 20, 30));
        add("leap_clamp",   B_INC,         1, 1, 0, mkd(2025, 2, 28, 10, 20, 30));
        add("leap_back",    B_DEC,         1, 1, 0, mkd(2024, 2, 28, 10, 20, 30));
        add("ok_commit",    B_OK,          1, 0, 1, mkd(2024, 2, 28, 10, 20, 30));
        add("ok_idle",      B_NONE,        0, 0, 0, mkd(2024, 2, 28, 10, 20, 30));

        bc = mkd(1900, 2, 1, 0, 0, 0);
        add("cap_1900",     B_MODE,        1, 1, 0, mkd(1900, 2, 1, 0, 0, 0));
        add("m1900_a",      B_MODE,        1, 2, 0, mkd(1900, 2, 1, 0, 0, 0));
        add("m1900_b",      B_MODE,        1, 3, 0, mkd(1900, 2, 1, 0, 0, 0));
        add("day_1900",     B_DEC,         1, 3, 0, mkd(1900, 2, 28, 0, 0, 0));
        add("cancel_1900",  B_CANCEL,      0, 0, 0, mkd(1900, 2, 28, 0, 0, 0));

        bc = mkd(2000, 2, 1, 0, 0, 0);
        add("cap_2000",     B_MODE,        1, 1, 0, mkd(2000, 2, 1, 0, 0, 0));
        add("m2000_a",      B_MODE,        1, 2, 0, mkd(2000, 2, 1, 0, 0, 0));
        add("m2000_b",      B_MODE,        1, 3, 0, mkd(2000, 2, 1, 0, 0, 0));
        add("day_2000",     B_DEC,         1, 3, 0, mkd(2000, 2, 29, 0, 0, 0));
        add("cancel_ok",    B_CANCEL|B_OK, 0, 0, 0, mkd(2000, 2, 29, 0, 0, 0));

        bc = mkd(2099, 12, 31, 23, 59, 59);
        add("cap_2099",     B_MODE,        1, 1, 0, mkd(2099, 12, 31, 23, 59, 59));
        add("year_wrap_up", B_INC,         1, 1, 0, mkd(1900, 12, 31, 23, 59, 59));
        add("year_wrap_dn", B_DEC,         1, 1, 0, mkd(2099, 12, 31, 23, 59, 59));
        add("to_mont2",     B_MODE,        1, 2, 0, mkd(2099, 12, 31, 23, 59, 59));
        add("mont_wrap_up", B_INC,         1, 2, 0, mkd(2099, 1, 31, 23, 59, 59));
        add("mont_wrap_dn", B_DEC,         1, 2, 0, mkd(2099, 12, 31, 23, 59, 59));
        add("mont_clamp",   B_DEC,         1, 2, 0, mkd(2099, 11, 30, 23, 59, 59));
        add("to_day2",      B_MODE,        1, 3, 0, mkd(2099, 11, 30, 23, 59, 59));
        add("to_hour2",     B_MODE,        1, 4, 0, mkd(2099, 11, 30, 23, 59, 59));
        add("to_min2",      B_MODE,        1, 5, 0, mkd(2099, 11, 30, 23, 59, 59));
        add("ok_in_min",    B_OK,          1, 0, 1, mkd(2099, 11, 30, 23, 59, 59));
        add("ok_min_idle",  B_NONE,        0, 0, 0, mkd(2099, 11, 30, 23, 59, 59));
        add("cap_again",    B_MODE,        1, 1, 0, mkd(2099, 12, 31, 23, 59, 59));
        add("adv_mont",     B_MODE,        1, 2, 0, mkd(2099, 12, 31, 23, 59, 59));
        add("adv_day",      B_MODE,        1, 3, 0, mkd(2099, 12, 31, 23, 59, 59));
        add("adv_hour",     B_MODE,        1, 4, 0, mkd(2099, 12, 31, 23, 59, 59));
        add("adv_min",      B_MODE,        1, 5, 0, mkd(2099, 12, 31, 23, 59, 59));
        add("min_wrap",     B_INC,         1, 5, 0, mkd(2099, 12, 31, 23, 0, 59));
        add("cancel_min",   B_CANCEL,      0, 0, 0, mkd(2099, 12, 31, 23, 0, 59));

        bc = mkd(2150, 3, 15, 12, 30, 45);
        add("clamp_hi",     B_MODE,        1, 1, 0, mkd(2099, 3, 15, 12, 30, 45));
        add("clamp_hi_cx",  B_CANCEL,      0, 0, 0, mkd(2099, 3, 15, 12, 30, 45));
        bc = mkd(1850, 6, 15, 1, 2, 3);
        add("clamp_lo",     B_MODE,        1, 1, 0, mkd(1900, 6, 15, 1, 2, 3));
        add("clamp_lo_cx",  B_CANCEL,      0, 0, 0, mkd(1900, 6, 15, 1, 2, 3));

        rst_n = 1'b0;
        btn_v = B_NONE;
        cur_v = mkd(2024, 2, 28, 23, 59, 58);
        #12;
        check("reset", 0, 0, 0, r0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cur_v = vecs[i].cur;
            step(vecs[i].btn);
            check(vecs[i].name, vecs[i].sm, vecs[i].fs, vecs[i].ld, vecs[i].exp);
        end

        // Timeout: 29 silent cycles stay in S_DAY, the 30th aborts without load.
        t = mkd(2030, 7, 4, 8, 9, 10);
        cur_v = t;
        step(B_MODE); step(B_MODE); step(B_MODE);
        check("to_enter_day", 1, 3, 0, t);
        for (int k = 1; k <= 29; k++) begin
            step(B_NONE);
            check($sformatf("to_wait%0d", k), 1, 3, 0, t);
        end
        step(B_NONE);
        check("to_expired", 0, 0, 0, t);

        // Any button pulse restarts the timeout count.
        step(B_MODE); step(B_MODE); step(B_MODE);
        for (int k = 0; k < 20; k++) step(B_NONE);
        step(B_INC | B_DEC);
        check("to_kick", 1, 3, 0, t);
        for (int k = 0; k < 29; k++) step(B_NONE);
        check("to_rearmed", 1, 3, 0, t);
        step(B_NONE);
        check("to_expired2", 0, 0, 0, t);

        // Asynchronous reset while editing the hour.
        step(B_MODE); step(B_MODE); step(B_MODE); step(B_MODE);
        check("rst_in_hour", 1, 4, 0, t);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 0, 0, 0, r0);
        #2 rst_n = 1'b1;
        step(B_NONE);
        check("rst_release", 0, 0, 0, r0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
User time-set controller for the century clock counter chain (sec/min/hour/day/mont/year).
- Captures the live time into shadow registers and walks the user through each field (year, month, day, hour, minute, second) using debounced single-cycle button pulses.
- Edits fields with calendar-correct wrap, month-length and leap-year rules.
- Issues a one-cycle load to the clock counter on commit.
- Sits between the button debouncers and the clock counter's parallel-load port.

Parameters:
YEAR_MIN, 1900, lowest settable year (inclusive)
YEAR_MAX, 2099, highest settable year (inclusive)
TIMEOUT, 30, clk_1Hz cycles with no button activity before set mode aborts

Ports:
clk_1Hz  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  pulse: enter set mode / advance to next field
btn_inc  input  1  pulse: increment selected field
btn_dec  input  1  pulse: decrement selected field
btn_ok  input  1  pulse: commit immediately
btn_cancel  input  1  pulse: abort without load
cur_sec  input  6  live seconds 0..59
cur_min  input  6  live minutes 0..59
cur_hour  input  5  live hours 0..23
cur_day  input  5  live day 1..31
cur_mont  input  4  live month 1..12
cur_year  input  13  live year
set_mode  output  1  high while editing
field_sel  output  3  0 none, 1 year, 2 mont, 3 day, 4 hour, 5 min, 6 sec
load  output  1  one-cycle pulse: clock counter loads ld_*
ld_sec  output  6  shadow seconds
ld_min  output  6  shadow minutes
ld_hour  output  5  shadow hours
ld_day  output  5  shadow day
ld_mont  output  4  shadow month
ld_year  output  13  shadow year

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; set_mode=0, field_sel=0, load=0.
  - ld_sec=0, ld_min=0, ld_hour=0, ld_day=1, ld_mont=1, ld_year=YEAR_MIN.
  - Timeout counter=0.
- States: IDLE, S_YEAR, S_MONT, S_DAY, S_HOUR, S_MIN, S_SEC, COMMIT.
- IDLE:
  - btn_mode -> next cycle S_YEAR, set_mode=1.
  - On that edge, shadow regs capture cur_*.
  - cur_year outside [YEAR_MIN,YEAR_MAX] is clamped to the nearest bound at capture.
  - Other buttons are ignored.
- Field sequence on btn_mode: S_YEAR->S_MONT->S_DAY->S_HOUR->S_MIN->S_SEC->COMMIT.
- btn_ok in any S_* -> COMMIT.
- btn_cancel in any S_* -> IDLE; no load; shadow regs hold their values.
- COMMIT lasts exactly one cycle: load=1, set_mode=1, field_sel=0; then IDLE.
  - Latency: btn_ok edge -> load high on the following cycle.
- Button priority in the same cycle: cancel > ok > mode > inc/dec.
  - inc and dec together -> field unchanged.
  - mode together with inc advances the field only.
- Inc/dec wrap (modular, one step per pulse):
  - sec, min: 0..59.
  - hour: 0..23.
  - mont: 1..12.
  - year: YEAR_MIN..YEAR_MAX, wrapping in both directions.
  - day: 1..dim, where dim = days_in_month(ld_mont, ld_year).
- Leap year: divisible by 4 and (not divisible by 100 or divisible by 400).
- Day clamp: whenever ld_mont or ld_year changes, ld_day is set to min(ld_day, new dim) in the same cycle.
- Timeout:
  - Counter resets on any button pulse in an S_* state.
  - Reaching TIMEOUT -> IDLE, no load (same as cancel).
  - Counter is held at 0 in IDLE and COMMIT.
- field_sel encodes the current S_* state and is 0 otherwise.
- ld_* are stable outside COMMIT. The counter samples them only when load=1.
- Reset mid-edit: immediate return to reset values; no load pulse is generated.
- All outputs are registered; there is no combinational path from buttons to outputs.

Decomposition:
- Package clock_set_pkg:
  - state enum;
  - field_sel codes;
  - width constants (SEC_W=6, MIN_W=6, HOUR_W=5, DAY_W=5, MONT_W=4, YEAR_W=13);
  - field limits (59, 59, 23, 12).
- Sub-module days_in_month: combinational (mont[3:0], year[12:0]) -> dim[4:0] with the leap rule. It is shared with the clock counter's day-rollover logic.

Test Plan:
- Capture: cur = 2024-02-28 23:59:58; pulse btn_mode -> set_mode=1, field_sel=1, ld_* = 2024/2/28/23/59/58.
- Leap/clamp: shadow 2024-02-29; in S_YEAR pulse btn_inc -> ld_year=2025, ld_day=28. Then btn_dec -> 2024, ld_day stays 28.
- Century rule: year 1900, month 2, day 1, S_DAY, pulse btn_dec -> ld_day=28. Same stimulus with year 2000 -> 29.
- Wrap: S_SEC with ld_sec=59, btn_inc -> 0. S_HOUR with 0, btn_dec -> 23. S_YEAR with YEAR_MAX, btn_inc -> YEAR_MIN.
- Commit/cancel:
  - btn_ok in S_MIN -> one-cycle load=1 with the edited values, then IDLE.
  - btn_cancel in S_MIN -> no load, set_mode=0.
  - cancel+ok in the same cycle -> no load.
- Timeout/reset: enter S_DAY and idle 30 cycles -> IDLE, load never asserted. Assert rst_n=0 mid-S_HOUR -> all outputs at reset values immediately.
